// File: rtl/decoder_16.sv
// decoder_16 : 4-to-16 line decoder with active-low outputs and two
// active-low enables, modelled on the 74154.
//
// Ports:
//   clk_sys  in   system clock, rising edge
//   reset    in   synchronous reset, active high
//   en1_     in   enable 1, active low
//   en2_     in   enable 2, active low
//   a,b,c,d  in   select code, a = LSB, d = MSB
//   o_       out  [0:15] combinational decoded outputs, active low
//   oq_      out  [0:15] o_ registered on clk_sys, active low
//   none_    out  registered; low when any bit of oq_ is low
//   selq     out  [3:0] registered select code   (DECODER16_SEL_OUT_EN only)
//   selv     out  registered enabled flag        (DECODER16_SEL_OUT_EN only)
//
// Optional feature macro: DECODER16_SEL_OUT_EN adds the selq/selv outputs.
module decoder_16 (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        en1_,
  input  logic        en2_,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic [0:15] o_,
  output logic [0:15] oq_,
`ifdef DECODER16_SEL_OUT_EN
  output logic [3:0]  selq,
  output logic        selv,
`endif
  output logic        none_
);

  logic [3:0] sel;
  logic       enabled;

  assign sel = {d, c, b, a};

  // An X/Z on either enable makes this condition unknown, which the if
  // below treats as false, so unknown enables leave every output high.
  assign enabled = (en1_ == 1'b0) && (en2_ == 1'b0);

  // Index 0 of the [0:15] vector is the leftmost bit, matching the TTL
  // part's output numbering.
  always_comb begin
    o_ = '1;
    if (enabled) begin
      o_[sel] = 1'b0;
    end
  end

  // Registered copy of the decoder
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      oq_   <= '1;
      none_ <= 1'b1;
    end else begin
      oq_   <= o_;
      none_ <= &o_;
    end
  end

`ifdef DECODER16_SEL_OUT_EN
  // Registered select code and enable flag, aligned with oq_
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      selq <= 4'd0;
      selv <= 1'b0;
    end else begin
      selq <= sel;
      selv <= enabled;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_16.sv
// tb_decoder_16 : randomized and directed stimulus for decoder_16. The
// combinational output is checked right after each input change; expected
// registered outputs go into a queue that a monitor drains after each edge.
module tb_decoder_16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        en1_, en2_, a, b, c, d;
  logic [0:15] o_, oq_;
  logic        none_;
`ifdef DECODER16_SEL_OUT_EN
  logic [3:0]  selq;
  logic        selv;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] oq;
    logic        none;
    logic [3:0]  selq;
    logic        selv;
  } exp_t;

  exp_t exp_q[$];

  decoder_16 dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .en1_    (en1_),
    .en2_    (en2_),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .o_      (o_),
    .oq_     (oq_),
`ifdef DECODER16_SEL_OUT_EN
    .selq    (selq),
    .selv    (selv),
`endif
    .none_   (none_)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference: all ones, except the line numbered sel counted from the
  // left (the most significant position) is pulled low when both enables
  // are low.
  function automatic logic [15:0] ref_dec(input logic e1, input logic e2,
                                          input int sel);
    logic [15:0] r;
    r = 16'hFFFF;
    if (e1 == 1'b0 && e2 == 1'b0)
      r = 16'hFFFF - (16'h8000 >> sel);
    return r;
  endfunction

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Apply one cycle of stimulus, check o_ immediately, and queue what the
  // registered outputs must show after the next rising edge.
  task automatic step(input logic rst, input logic e1, input logic e2,
                      input int sel);
    logic [15:0] eo;
    logic [3:0]  s4;
    exp_t        e;
    @(negedge clk_sys);
    s4 = sel[3:0];
    reset = rst;
    en1_ = e1;
    en2_ = e2;
    {d, c, b, a} = s4;
    #1;
    eo = ref_dec(e1, e2, sel);
    check16("o_comb", o_, eo);
    if (rst) begin
      e.oq = 16'hFFFF; e.none = 1'b1; e.selq = 4'd0; e.selv = 1'b0;
    end else begin
      e.oq   = eo;
      e.none = (eo == 16'hFFFF);
      e.selq = s4;
      e.selv = (e1 == 1'b0 && e2 == 1'b0);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: the registered outputs are presented every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check16("oq_", oq_, e.oq);
        check1("none_", none_, e.none);
`ifdef DECODER16_SEL_OUT_EN
        check1("selv", selv, e.selv);
        if (e.selv) begin
          check16("selq", {12'd0, selq}, {12'd0, e.selq});
          check1("oq_at_selq", oq_[selq], 1'b0);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    en1_ = 1'b1; en2_ = 1'b1;
    {d, c, b, a} = 4'd0;

    // Reset, including reset with the decoder enabled
    step(1, 1, 1, 3);
    step(1, 0, 0, 7);

    // Disabled combinations with various codes
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, i * 5);
      step(0, 0, 1, i * 3 + 1);
      step(0, 1, 0, 15 - i);
    end

    // Enabled sweep of every code
    for (int s = 0; s < 16; s++) step(0, 0, 0, s);

    // sel 9, then drop out by raising en1_
    step(0, 0, 0, 9);
    step(0, 1, 0, 9);
    step(0, 1, 0, 9);

    // sel 5 with a one-cycle reset pulse in the middle
    step(0, 0, 0, 5);
    step(1, 0, 0, 5);
    step(0, 0, 0, 5);

    // sel 12 enabled then disabled
    step(0, 0, 0, 12);
    step(0, 0, 1, 12);

    // Random traffic, enables biased toward enabled
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 15)));
    end

    // Let the monitor drain; anything left over means an edge was missed
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk_sys);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
